// File: rtl/mux21_arbiter.sv
// Two-requester round-robin burst arbiter that drives the select line of a mux21.
// Grants are bounded by burst-end (last beat, beat limit or abandon) and alternate on contention.
module mux21_arbiter #(
  parameter int MAX_BEATS = 16,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          last_a,
  input  logic          last_b,
  input  logic          dout_ready,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sel,
  output logic          busy,
  output logic [CW-1:0] beat_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic cur_is_b, cur_req, cur_last, oth_req;
  logic beat, at_limit, burst_end, win_b;

  // The current owner's view of the request lines; only meaningful in GNT_A/GNT_B.
  assign cur_is_b  = (state_q == GNT_B);
  assign cur_req   = cur_is_b ? req_b  : req_a;
  assign cur_last  = cur_is_b ? last_b : last_a;
  assign oth_req   = cur_is_b ? req_a  : req_b;
  assign beat      = cur_req & dout_ready;
  // The count excludes the current beat, so the limit is hit when it reads MAX_BEATS-1.
  assign at_limit  = (cnt_q == CW'(MAX_BEATS - 1));
  assign burst_end = ~cur_req | (beat & (cur_last | at_limit));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    win_b   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          win_b   = req_b & (~req_a | prio_q);
          state_d = win_b ? GNT_B : GNT_A;
          prio_d  = ~win_b;
          sel_d   = win_b;
        end
      end
      GNT_A, GNT_B: begin
        if (burst_end) begin
          // Ending owner yields to the other side; it keeps the grant only if the other is idle.
          prio_d = ~cur_is_b;
          cnt_d  = '0;
          if (oth_req) begin
            state_d = cur_is_b ? GNT_A : GNT_B;
            sel_d   = ~cur_is_b;
          end else if (!cur_req) begin
            state_d = IDLE;
          end
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_a    = (state_q == GNT_A);
  assign gnt_b    = (state_q == GNT_B);
  assign busy     = (state_q != IDLE);
  assign sel      = sel_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Scoreboard bench for mux21_arbiter: a behavioural model pushes expected outputs each edge,
// and the DUT outputs are popped and compared shortly after that edge.
module tb_mux21_arbiter;

  localparam int MAXB = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_a = 1'b0, req_b = 1'b0, last_a = 1'b0, last_b = 1'b0, dout_ready = 1'b0;
  logic          gnt_a, gnt_b, sel, busy;
  logic [CW-1:0] beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mux21_arbiter #(.MAX_BEATS(MAXB), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .req_b      (req_b),
    .last_a     (last_a),
    .last_b     (last_b),
    .dout_ready (dout_ready),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .sel        (sel),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = A, 1 = B; m_own = -1 means idle.
  int m_own = -1, m_prio = 0, m_cnt = 0, m_sel = 0;
  logic [15:0] sb_q[$];

  task automatic model_step();
    int r[2], l[2];
    int x, o, w;
    bit done;
    r[0] = int'(req_a); r[1] = int'(req_b);
    l[0] = int'(last_a); l[1] = int'(last_b);
    if (reset) begin
      m_own = -1; m_prio = 0; m_cnt = 0; m_sel = 0;
    end else if (m_own < 0) begin
      if (r[0] != 0 || r[1] != 0) begin
        if (r[0] != 0 && r[1] != 0) w = m_prio;
        else w = (r[1] != 0) ? 1 : 0;
        m_own = w; m_prio = 1 - w; m_sel = w;
      end
    end else begin
      x = m_own; o = 1 - x;
      done = 0;
      if (r[x] == 0) done = 1;
      else if (dout_ready) begin
        m_cnt++;
        if (l[x] != 0 || m_cnt == MAXB) done = 1;
      end
      if (done) begin
        m_prio = o; m_cnt = 0;
        if (r[o] != 0) begin m_own = o; m_sel = o; end
        else if (r[x] == 0) m_own = -1;
      end
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic ga, gb;
    ga = (m_own == 0);
    gb = (m_own == 1);
    return {4'b0, ga, gb, 1'(m_sel), ga | gb, 8'(m_cnt)};
  endfunction

  always @(posedge clk) begin
    logic [15:0] exp_v;
    model_step();
    sb_q.push_back(model_vec());
    #2;
    if (sb_q.size() == 0) begin
      check("sb_empty", 16'h1, 16'h0);
    end else begin
      exp_v = sb_q.pop_front();
      check("outputs", {4'b0, gnt_a, gnt_b, sel, busy, beat_cnt}, exp_v);
      check("mutex", 16'(gnt_a & gnt_b), 16'h0);
    end
  end

  task automatic cyc(input logic ra, input logic la, input logic rb, input logic lb,
                     input logic rdy, input logic rst = 1'b0);
    @(negedge clk);
    req_a = ra; last_a = la; req_b = rb; last_b = lb; dout_ready = rdy; reset = rst;
  endtask

  initial begin
    // Reset, then idle.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0);
    check("idle_after_reset", {12'b0, gnt_a, gnt_b, sel, busy}, 16'h0);

    // Single A burst of 3 beats, then release.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Contention: 2-beat bursts alternate A/B back-to-back.
    cyc(1, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, i[0], 1, i[0], 1);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Beat limit: B streams with no last while A waits.
    cyc(0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 1);
    cyc(1, 1, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Backpressure then abandon with B waiting.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 1, 0, 0);
    check("cnt_frozen", 16'(beat_cnt), 16'd1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Reset during the 2nd beat of a B burst.
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    check("reset_mid_burst", {4'b0, gnt_a, gnt_b, sel, busy, beat_cnt}, 16'h0);
    // After reset prio is A: contention from idle must grant A.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("prio_after_reset", {14'b0, gnt_a, gnt_b}, 16'b10);
    cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));

    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
